// File: rtl/branch_resolve_unit_if.sv
// Fetch/decode-side bundle for the branch resolve unit: F and D slot inputs,
// redirect and predictor-training outputs, and the performance counters.
interface branch_resolve_unit_if;
    localparam int unsigned XLEN = 32;

    logic            valid_F;
    logic [XLEN-1:0] PC_F;
    logic            pred_jump_F;
    logic [XLEN-1:0] pred_target_F;
    logic            stall_D;
    logic            flush_D;
    logic            is_branch_D;
    logic            PC_src_D;
    logic [XLEN-1:0] PC_target_D;

    logic            kill_F;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic            upd_taken;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic [XLEN-1:0] br_cnt;
    logic [XLEN-1:0] miss_cnt;

    // Pipeline/driver side.
    modport master (
        output valid_F, PC_F, pred_jump_F, pred_target_F,
        output stall_D, flush_D, is_branch_D, PC_src_D, PC_target_D,
        input  kill_F, redirect_valid, redirect_pc,
        input  upd_valid, upd_taken, upd_pc, upd_target,
        input  br_cnt, miss_cnt
    );

    // Resolve unit side.
    modport slave (
        input  valid_F, PC_F, pred_jump_F, pred_target_F,
        input  stall_D, flush_D, is_branch_D, PC_src_D, PC_target_D,
        output kill_F, redirect_valid, redirect_pc,
        output upd_valid, upd_taken, upd_pc, upd_target,
        output br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves control transfers in D against the F-stage prediction, redirects
// fetch on a mispredict and trains the predictor. BRU_PERF_CNT_EN adds counters.
module branch_resolve_unit (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSN_SZ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_e;

    state_e          state_q, state_d;

    logic            d_valid_q, d_valid_d;
    logic [XLEN-1:0] d_pc_q, d_pc_d;
    logic            d_pred_jump_q, d_pred_jump_d;
    logic [XLEN-1:0] d_pred_target_q, d_pred_target_d;

    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            upd_valid_q, upd_valid_d;
    logic            upd_taken_q, upd_taken_d;
    logic [XLEN-1:0] upd_pc_q, upd_pc_d;
    logic [XLEN-1:0] upd_target_q, upd_target_d;

    logic            resolve_c;
    logic            taken_c;
    logic            mispredict_c;
    logic            kill_c;
    logic [XLEN-1:0] correct_pc_c;

    // Resolve decision for the instruction currently in D.
    always_comb begin
        resolve_c    = d_valid_q && !bus.stall_D && !bus.flush_D && (state_q == IDLE);
        taken_c      = bus.is_branch_D && bus.PC_src_D;
        mispredict_c = resolve_c &&
                       ((taken_c && (!d_pred_jump_q || (d_pred_target_q != bus.PC_target_D))) ||
                        (d_pred_jump_q && !taken_c));
        correct_pc_c = taken_c ? bus.PC_target_D : d_pc_q + XLEN'(INSN_SZ);
        kill_c       = mispredict_c || (state_q == REDIR);
    end

    // Next-state, F->D slot and training register updates.
    always_comb begin
        state_d         = state_q;
        d_valid_d       = d_valid_q;
        d_pc_d          = d_pc_q;
        d_pred_jump_d   = d_pred_jump_q;
        d_pred_target_d = d_pred_target_q;
        redirect_pc_d   = redirect_pc_q;
        upd_valid_d     = 1'b0;
        upd_taken_d     = upd_taken_q;
        upd_pc_d        = upd_pc_q;
        upd_target_d    = upd_target_q;

        case (state_q)
            IDLE:    if (mispredict_c) state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (mispredict_c) begin
            redirect_pc_d = correct_pc_c;
        end

        if (resolve_c && (bus.is_branch_D || d_pred_jump_q)) begin
            upd_valid_d  = 1'b1;
            upd_taken_d  = taken_c;
            upd_pc_d     = d_pc_q;
            upd_target_d = bus.PC_target_D;
        end

        if (!bus.stall_D) begin
            d_valid_d       = bus.valid_F;
            d_pc_d          = bus.PC_F;
            d_pred_jump_d   = bus.pred_jump_F;
            d_pred_target_d = bus.pred_target_F;
        end
        // A squashed slot stays empty even while stalled.
        if (bus.flush_D || kill_c) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            d_valid_q       <= 1'b0;
            d_pc_q          <= '0;
            d_pred_jump_q   <= 1'b0;
            d_pred_target_q <= '0;
            redirect_pc_q   <= '0;
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            upd_pc_q        <= '0;
            upd_target_q    <= '0;
        end else begin
            state_q         <= state_d;
            d_valid_q       <= d_valid_d;
            d_pc_q          <= d_pc_d;
            d_pred_jump_q   <= d_pred_jump_d;
            d_pred_target_q <= d_pred_target_d;
            redirect_pc_q   <= redirect_pc_d;
            upd_valid_q     <= upd_valid_d;
            upd_taken_q     <= upd_taken_d;
            upd_pc_q        <= upd_pc_d;
            upd_target_q    <= upd_target_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [XLEN-1:0] br_cnt_q, br_cnt_d;
    logic [XLEN-1:0] miss_cnt_q, miss_cnt_d;

    // Counters wrap naturally at 2^XLEN.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resolve_c && bus.is_branch_D) br_cnt_d = br_cnt_q + XLEN'(1);
        if (mispredict_c)                 miss_cnt_d = miss_cnt_q + XLEN'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.br_cnt   = br_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.br_cnt   = '0;
    assign bus.miss_cnt = '0;
`endif

    assign bus.kill_F         = kill_c;
    assign bus.redirect_valid = (state_q == REDIR);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_target     = upd_target_q;
endmodule
